// File: rtl/dircc_mem_pkg.sv
// Shared types and helpers for the dircc dual-port processing memory.
// Covers the controller state, legal parameter values and port B lane mapping.
package dircc_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 2;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic bit ratio_is_legal(input int ratio);
    return (ratio == 1) || (ratio == 2) || (ratio == 4);
  endfunction

  function automatic bit latency_is_legal(input int latency);
    return (latency >= LATENCY_MIN) && (latency <= LATENCY_MAX);
  endfunction

  // Port B addresses are little-endian lane groups inside a port A word.
  function automatic int b_word_index(input int b_addr, input int ratio);
    return b_addr / ratio;
  endfunction

  function automatic int b_lane_group(input int b_addr, input int ratio);
    return b_addr % ratio;
  endfunction

endpackage

// File: rtl/dircc_mem_read_pipe.sv
// Read-return pipeline for one port: valid/data shift register of LATENCY stages.
// Out-of-range reads return zero; each stage holds its data while no read passes.
module dircc_mem_read_pipe
  import dircc_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_valid,
  input  logic              rd_err,
  input  logic [DATA_W-1:0] rd_data,
  output logic              readdatavalid,
  output logic [DATA_W-1:0] readdata
);

  logic [LATENCY-1:0] valid_q, valid_d;
  logic [DATA_W-1:0]  data_q [LATENCY];
  logic [DATA_W-1:0]  data_d [LATENCY];

  always_comb begin
    valid_d = '0;
    data_d  = data_q;
    valid_d[0] = rd_valid;
    if (rd_valid) begin
      data_d[0] = rd_err ? '0 : rd_data;
    end
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) begin
        data_d[i] = data_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign readdatavalid = valid_q[LATENCY-1];
  assign readdata      = data_q[LATENCY-1];

endmodule

// File: rtl/dircc_dual_port_processing_mem.sv
// Dual-port node processing memory: wide port A (Nios), narrow port B (mailbox/DMA),
// byte enables, pipelined reads, hardware clear engine and sticky error flags.
module dircc_dual_port_processing_mem
  import dircc_mem_pkg::*;
#(
  parameter int DATA_W_A       = 32,
  parameter int RATIO          = 2,
  parameter int DEPTH_A        = 7500,
  parameter int ADDR_W_A       = 13,
  parameter int ADDR_W_B       = 14,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter     INIT_FILE      = ""
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_W_A-1:0]          a_address,
  input  logic                         a_chipselect,
  input  logic                         a_read,
  input  logic                         a_write,
  input  logic [DATA_W_A/8-1:0]        a_byteenable,
  input  logic [DATA_W_A-1:0]          a_writedata,
  output logic [DATA_W_A-1:0]          a_readdata,
  output logic                         a_readdatavalid,
  output logic                         a_waitrequest,
  input  logic [ADDR_W_B-1:0]          b_address,
  input  logic                         b_chipselect,
  input  logic                         b_read,
  input  logic                         b_write,
  input  logic [DATA_W_A/RATIO/8-1:0]  b_byteenable,
  input  logic [DATA_W_A/RATIO-1:0]    b_writedata,
  output logic [DATA_W_A/RATIO-1:0]    b_readdata,
  output logic                         b_readdatavalid,
  output logic                         b_waitrequest,
  input  logic                         clear_req,
  output logic                         clear_busy,
  output logic                         coll_flag,
  output logic                         addr_err
);

  localparam int DATA_W_B = DATA_W_A / RATIO;
  localparam int BYTES_A  = DATA_W_A / 8;
  localparam int BYTES_B  = DATA_W_B / 8;
  localparam int IDX_W    = (clog2(DEPTH_A) < 1) ? 1 : clog2(DEPTH_A);

  generate
    if (!ratio_is_legal(RATIO) || !latency_is_legal(READ_LATENCY) ||
        (DATA_W_A % (8 * RATIO) != 0)) begin : g_bad_params
      $error("dircc_dual_port_processing_mem: illegal RATIO, READ_LATENCY or DATA_W_A");
    end
    if (INIT_FILE != "") begin : g_init_note
      $info("dircc_dual_port_processing_mem: array preload comes from the configuration image");
    end
  endgenerate

  mem_state_e         state_q, state_d;
  logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               busy_q, busy_d;
  logic               coll_q, coll_d;
  logic               aerr_q, aerr_d;

  logic [DATA_W_A-1:0] ram [DEPTH_A];

  logic                a_acc, a_wr, a_rd, a_oor;
  logic [IDX_W-1:0]    a_idx;
  logic                b_acc, b_wr, b_rd, b_oor;
  logic [IDX_W-1:0]    b_idx;
  int                  b_word, b_group;
  logic [BYTES_A-1:0]  b_be_wide;
  logic [DATA_W_A-1:0] b_wd_wide;
  logic                collision;
  logic [DATA_W_A-1:0] a_rd_word, b_rd_word;
  logic [DATA_W_B-1:0] b_rd_lane;

  always_comb begin
    a_acc     = a_chipselect & (a_read | a_write) & ~busy_q;
    a_wr      = a_acc & a_write;
    a_rd      = a_acc & a_read & ~a_write;
    a_oor     = int'(a_address) >= DEPTH_A;
    a_idx     = a_oor ? '0 : IDX_W'(a_address);

    b_acc     = b_chipselect & (b_read | b_write) & ~busy_q;
    b_wr      = b_acc & b_write;
    b_rd      = b_acc & b_read & ~b_write;
    b_word    = b_word_index(int'(b_address), RATIO);
    b_group   = b_lane_group(int'(b_address), RATIO);
    b_oor     = b_word >= DEPTH_A;
    b_idx     = b_oor ? '0 : IDX_W'(b_word);
    b_be_wide = BYTES_A'(b_byteenable) << (b_group * BYTES_B);
    b_wd_wide = DATA_W_A'(b_writedata) << (b_group * DATA_W_B);

    // Only lanes enabled on both ports count; disjoint lanes of one word are legal.
    collision = a_wr & b_wr & ~a_oor & ~b_oor & (a_idx == b_idx) &
                (|(a_byteenable & b_be_wide));

    a_rd_word = ram[a_idx];
    b_rd_word = ram[b_idx];
    b_rd_lane = DATA_W_B'(b_rd_word >> (b_group * DATA_W_B));
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy_d    = busy_q;
    coll_d    = coll_q | collision;
    aerr_d    = aerr_q | (a_acc & a_oor) | (b_acc & b_oor);
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == IDX_W'(DEPTH_A - 1)) begin
          state_d   = READY;
          busy_d    = 1'b0;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + IDX_W'(1);
        end
      end
      READY: begin
        if (clear_req) begin
          state_d   = CLEAR;
          busy_d    = 1'b1;
          clr_cnt_d = '0;
          coll_d    = 1'b0;
          aerr_d    = 1'b0;
        end
      end
      default: begin
        state_d = READY;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : READY;
      busy_q    <= CLEAR_ON_RESET;
      clr_cnt_q <= '0;
      coll_q    <= 1'b0;
      aerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      clr_cnt_q <= clr_cnt_d;
      coll_q    <= coll_d;
      aerr_q    <= aerr_d;
    end
  end

  // Port A lanes are written after port B so A wins any overlapping lane.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (state_q == CLEAR) begin
        ram[clr_cnt_q] <= '0;
      end else begin
        for (int j = 0; j < BYTES_A; j++) begin
          if (b_wr && !b_oor && b_be_wide[j]) begin
            ram[b_idx][8*j +: 8] <= b_wd_wide[8*j +: 8];
          end
          if (a_wr && !a_oor && a_byteenable[j]) begin
            ram[a_idx][8*j +: 8] <= a_writedata[8*j +: 8];
          end
        end
      end
    end
  end

  dircc_mem_read_pipe #(
    .DATA_W  (DATA_W_A),
    .LATENCY (READ_LATENCY)
  ) u_read_pipe_a (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_valid      (a_rd),
    .rd_err        (a_oor),
    .rd_data       (a_rd_word),
    .readdatavalid (a_readdatavalid),
    .readdata      (a_readdata)
  );

  dircc_mem_read_pipe #(
    .DATA_W  (DATA_W_B),
    .LATENCY (READ_LATENCY)
  ) u_read_pipe_b (
    .clk           (clk),
    .reset_n       (reset_n),
    .rd_valid      (b_rd),
    .rd_err        (b_oor),
    .rd_data       (b_rd_lane),
    .readdatavalid (b_readdatavalid),
    .readdata      (b_readdata)
  );

  assign a_waitrequest = busy_q;
  assign b_waitrequest = busy_q;
  assign clear_busy    = busy_q;
  assign coll_flag     = coll_q;
  assign addr_err      = aerr_q;

endmodule

// File: doc/dircc_dual_port_processing_mem.md
Name: dircc_dual_port_processing_mem

Overview:
Parametrised successor to the node processing memory: true dual-port on-chip RAM with asymmetric port widths (port B = port A width / RATIO), byte enables, pipelined Avalon-MM read with readdatavalid, and a hardware clear engine.
Sits between a node's Nios data master (port A) and the mailbox/DMA side (port B) in each dircc node.
Adds sticky collision and address-error status.

Parameters:
DATA_W_A, 32, port A data width in bits (multiple of 8).
RATIO, 2, port A/B width ratio; legal values 1, 2, 4. DATA_W_B = DATA_W_A/RATIO.
DEPTH_A, 7500, number of port A words. Port B depth = DEPTH_A*RATIO.
ADDR_W_A, 13, port A address width; ceil(log2(DEPTH_A)) or greater.
ADDR_W_B, 14, port B address width; at least ADDR_W_A + log2(RATIO).
READ_LATENCY, 1, read latency in cycles; legal values 1 or 2.
CLEAR_ON_RESET, 1, zero the whole array after reset release.
INIT_FILE, "", hex preload applied at configuration only.

Ports:
clk  in  1  single clock
reset_n  in  1  synchronous, active-low reset
a_address  in  ADDR_W_A  port A word address
a_chipselect, a_read, a_write  in  1 each  port A command
a_byteenable  in  DATA_W_A/8  port A byte lanes
a_writedata  in  DATA_W_A  port A write data
a_readdata  out  DATA_W_A  port A read data
a_readdatavalid  out  1  port A read data valid
a_waitrequest  out  1  port A stall
b_* (same set)  in/out  ADDR_W_B / DATA_W_B / DATA_W_B/8  port B equivalents
clear_req  in  1  one-cycle pulse; starts array clear
clear_busy  out  1  clear in progress
coll_flag  out  1  sticky same-cycle write collision
addr_err  out  1  sticky out-of-range access

Behaviour:
- Reset (reset_n low at a clk edge):
  - all readdata = 0, readdatavalid = 0, coll_flag = 0, addr_err = 0.
  - clear_busy = 1 and waitrequest = 1 if CLEAR_ON_RESET, else both 0.
  - Array contents are not changed by reset itself.
- FSM states:
  - CLEAR: a counter writes 0 to one port A word per cycle, addresses 0 to DEPTH_A-1, in DEPTH_A cycles. clear_busy = 1 and both waitrequests = 1 throughout. Leaves for READY the cycle after the last word is written.
  - READY: waitrequest = 0. clear_req = 1 moves to CLEAR on the next edge and also clears coll_flag and addr_err.
  - clear_req is ignored while in CLEAR.
  - Reset mid-clear aborts the sweep; the counter restarts at 0.
- Accepting commands:
  - A command is accepted when chipselect & (read|write) & !waitrequest.
  - read and write together on one port: the write is performed and the read is dropped (no readdatavalid).
- Port B mapping:
  - word index = b_address / RATIO.
  - lane group = b_address % RATIO; group 0 is the least-significant DATA_W_B bits (little-endian).
  - b_byteenable steers to the matching DATA_W_A/8 lanes; other lanes are untouched.
- Reads:
  - Fully pipelined, one per cycle per port.
  - readdata/readdatavalid appear READ_LATENCY edges after acceptance. readdatavalid is a one-cycle pulse; readdata holds its last value otherwise.
  - Reads accepted before CLEAR entry still complete.
- Mixed-port read-during-write to the same word: the reader gets OLD data.
- Collision: both ports write the same word in one cycle with overlapping enabled lanes.
  - Port A wins the overlapping lanes; port B's non-overlapping lanes are still written.
  - coll_flag is set on the next edge. Non-overlapping same-word writes do not set it.
- Out-of-range (word index >= DEPTH_A):
  - Writes are dropped.
  - Reads return 0 with readdatavalid asserted.
  - addr_err is set.

Decomposition:
- Package dircc_mem_pkg holds:
  - the FSM state enum {CLEAR, READY};
  - a clog2 function;
  - lane-mapping helper functions;
  - legal RATIO and READ_LATENCY constants, checked by an elaboration-time assertion.
- One sub-module, dircc_mem_read_pipe: READ_LATENCY-deep valid/data shift register with range-error zeroing. Instantiated once per port.
- The array is inferred from a behavioural byte-lane memory.

Test Plan:
- Reset, then release with CLEAR_ON_RESET=1, DEPTH_A=16 -> clear_busy high exactly 16 cycles, both waitrequests high meanwhile; subsequent read of every A word returns 0x0000_0000.
- A writes 0xDEADBEEF to word 5, be=1111; B reads addr 10 and 11 (RATIO=2) -> 0xBEEF then 0xDEAD, valid READ_LATENCY cycles after acceptance, back-to-back pulses.
- Same cycle: A writes 0x11223344 be=0011 to word 3; B writes 0xAABB to addr 6 (lanes 0-1) -> word 3 lanes 0-1 = 0x3344, coll_flag=1. Repeat with B addr 7 -> upper = 0xAABB, no new collision.
- A reads word 2 while B writes 0x5555 to addr 4 in the same cycle (old word = 0x0) -> A readdata = 0x0; a following read returns 0x0000_5555.
- A writes word 20 (DEPTH_A=16) -> no array change, addr_err=1; A read of word 20 -> readdata 0 with valid; clear_req -> addr_err=0, busy 16 cycles.
- reset_n low at clear cycle 7, high again -> clear restarts from 0 and takes the full 16 cycles; coll_flag and addr_err read 0.
